// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The FSM (master) reads the opcode and drives every select line and
// write enable. The datapath (slave) supplies the opcode and consumes
// the controls.
interface mc_control_fsm_if;
    logic [5:0] op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, state
    );

    modport slave (
        output op,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Main control unit of the multicycle CPU. A Moore machine that walks each
// instruction through fetch, decode, execute, memory and write-back, and
// drives every datapath mux select and write enable from its state.
// Control outputs are registered alongside the state: on each edge the
// controls for the state being entered are loaded, so they are glitch-free
// and always equal to the decode of the registered state.
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mc_control_fsm_if.master     bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl;

    function automatic logic isLegal(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
               (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
    endfunction

    // Next-state function; the opcode only matters in DECODE and MEMADR.
    function automatic state_t nextOf(input state_t s, input logic [5:0] opcode);
        state_t n;
        n = IDLE;
        case (s)
            IDLE:   n = FETCH;
            FETCH:  n = DECODE;
            DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) n = MEMADR;
                else if (opcode == OP_RTYPE)            n = EXEC;
                else if (opcode == OP_BEQ)              n = BRANCH;
                else if (opcode == OP_ADDI)             n = ADDIEX;
                else if (opcode == OP_J)                n = JUMP;
                else                                    n = FETCH;
            end
            MEMADR: n = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  n = MEMWB;
            EXEC:   n = ALUWB;
            ADDIEX: n = ADDIWB;
            MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: n = FETCH;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // Control word asserted while sitting in a given state; anything not
    // set here stays 0, including IDLE and the unused encodings.
    function automatic ctrl_t decodeCtrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            ADDIWB: c.reg_write = 1'b1;
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // State register plus registered controls for the state being entered;
    // reset clears both at once so no strobe survives reset assertion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ctrl  <= '0;
        end else begin
            state <= nextOf(state, bus.op);
            ctrl  <= decodeCtrl(nextOf(state, bus.op));
        end
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.state         = state;

    // The opcode only becomes valid in the IR at the edge entering DECODE,
    // so the illegal flag is formed from the registered state and the
    // (stable) IR opcode rather than being preloaded.
    assign bus.illegal_op = (state == DECODE) && !isLegal(bus.op);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for the multicycle control FSM: walks each instruction
// class through its state sequence, checks the full control word in every
// state, measures cycles per instruction and exercises asynchronous reset.
module tb_mc_control_fsm;

    // Control word layout:
    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
    //  alu_op[1:0], pc_source[1:0], illegal_op}
    localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] V_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] V_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] V_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] V_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] V_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] V_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] V_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] V_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] V_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] V_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] V_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    mc_control_fsm_if bus ();

    mc_control_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] getCtrl();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.illegal_op};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] opcode);
        bus.op = opcode;
    endtask

    // Check state, full control word and the exclusivity invariants at the
    // current sample point, then move on to the next falling edge.
    task automatic stepCheck(input string tag, input logic [3:0] expState,
                             input logic [16:0] expCtrl);
        checkOutput({tag, ".state"}, 32'(bus.state), 32'(expState));
        checkOutput({tag, ".ctrl"}, 32'(getCtrl()), 32'(expCtrl));
        checkOutput({tag, ".memExcl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
        checkOutput({tag, ".pcExcl"}, 32'(bus.pc_write & bus.pc_write_cond), 32'd0);
        @(negedge clk);
    endtask

    // Count cycles from this FETCH to the next one, bounded.
    task automatic measureCpi(input string tag, input logic [5:0] opcode,
                              input int expected);
        int cycles;
        applyStimulus(opcode);
        checkOutput({tag, ".startFetch"}, 32'(bus.state), 32'd1);
        cycles = 1;
        @(negedge clk);
        while (bus.state !== 4'd1 && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, ".cpi"}, 32'(cycles), 32'(expected));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.op   = 6'h00;

        // Three cycles in reset: everything must be quiet.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst.state", 32'(bus.state), 32'd0);
            checkOutput("rst.ctrl", 32'(getCtrl()), 32'(V_ZERO));
            @(negedge clk);
        end
        reset_n = 1'b1;
        checkOutput("idle.state", 32'(bus.state), 32'd0);
        checkOutput("idle.ctrl", 32'(getCtrl()), 32'(V_ZERO));
        @(negedge clk);

        // R-type
        stepCheck("r.fetch", 4'd1, V_FETCH);
        stepCheck("r.decode", 4'd2, V_DECODE);
        stepCheck("r.exec", 4'd7, V_EXEC);
        stepCheck("r.aluwb", 4'd8, V_ALUWB);

        // lw
        applyStimulus(6'h23);
        stepCheck("lw.fetch", 4'd1, V_FETCH);
        stepCheck("lw.decode", 4'd2, V_DECODE);
        stepCheck("lw.memadr", 4'd3, V_MEMADR);
        stepCheck("lw.memrd", 4'd4, V_MEMRD);
        stepCheck("lw.memwb", 4'd5, V_MEMWB);

        // sw
        applyStimulus(6'h2B);
        stepCheck("sw.fetch", 4'd1, V_FETCH);
        stepCheck("sw.decode", 4'd2, V_DECODE);
        stepCheck("sw.memadr", 4'd3, V_MEMADR);
        stepCheck("sw.memwr", 4'd6, V_MEMWR);

        // beq then j
        applyStimulus(6'h04);
        stepCheck("beq.fetch", 4'd1, V_FETCH);
        stepCheck("beq.decode", 4'd2, V_DECODE);
        stepCheck("beq.branch", 4'd9, V_BRANCH);
        applyStimulus(6'h02);
        stepCheck("j.fetch", 4'd1, V_FETCH);
        stepCheck("j.decode", 4'd2, V_DECODE);
        stepCheck("j.jump", 4'd12, V_JUMP);

        // Illegal opcode then addi
        applyStimulus(6'h3F);
        stepCheck("ill.fetch", 4'd1, V_FETCH);
        stepCheck("ill.decode", 4'd2, V_DECILL);
        applyStimulus(6'h08);
        stepCheck("addi.fetch", 4'd1, V_FETCH);
        stepCheck("addi.decode", 4'd2, V_DECODE);
        stepCheck("addi.ex", 4'd10, V_ADDIEX);
        stepCheck("addi.wb", 4'd11, V_ADDIWB);

        // Cycles per instruction for every class
        measureCpi("cpi.lw", 6'h23, 5);
        measureCpi("cpi.sw", 6'h2B, 4);
        measureCpi("cpi.r", 6'h00, 4);
        measureCpi("cpi.addi", 6'h08, 4);
        measureCpi("cpi.beq", 6'h04, 3);
        measureCpi("cpi.j", 6'h02, 3);
        measureCpi("cpi.ill", 6'h3F, 2);

        // Asynchronous reset in the middle of MEMRD
        applyStimulus(6'h23);
        stepCheck("ar.fetch", 4'd1, V_FETCH);
        stepCheck("ar.decode", 4'd2, V_DECODE);
        stepCheck("ar.memadr", 4'd3, V_MEMADR);
        checkOutput("ar.memrd.state", 32'(bus.state), 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ar.async.state", 32'(bus.state), 32'd0);
        checkOutput("ar.async.ctrl", 32'(getCtrl()), 32'(V_ZERO));
        @(negedge clk);
        checkOutput("ar.held.state", 32'(bus.state), 32'd0);
        checkOutput("ar.held.ctrl", 32'(getCtrl()), 32'(V_ZERO));
        reset_n = 1'b1;
        checkOutput("ar.release.state", 32'(bus.state), 32'd0);
        @(negedge clk);
        stepCheck("ar.recover", 4'd1, V_FETCH);
        stepCheck("ar.decode2", 4'd2, V_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control unit for the multicycle CPU datapath. It is a Moore state machine that decodes the 6-bit opcode latched in the instruction register and sequences every instruction through fetch, decode, execute, memory and write-back steps. On every cycle it drives the select lines of the datapath's 2:1 and 4:1 source muxes, plus all register, memory and PC write enables. It is the only block in the datapath that generates mux selects.

## Interface
- `OP_RTYPE`, default 6'b000000, R-type opcode
- `OP_LW`, default 6'b100011, load word
- `OP_SW`, default 6'b101011, store word
- `OP_BEQ`, default 6'b000100, branch on equal
- `OP_ADDI`, default 6'b001000, add immediate
- `OP_J`, default 6'b000010, jump
- `clk`  in  1  system clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode field from the instruction register, bits [31:26]
- `pc_write`  out  1  unconditional PC write
- `pc_write_cond`  out  1  PC write if ALU zero (branch)
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd
- `reg_write`  out  1  register file write
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = use funct field
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target; 11 is never driven
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode is decoded
- `state`  out  4  current state encoding, for debug

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12. Codes 13–15 are unused.
- All outputs are decoded from `state` only. Any output not listed for a state is 0.
- IDLE → FETCH unconditionally. IDLE asserts no outputs.
- FETCH: `mem_read`, `ir_write`, `alu_src_b`=01, `alu_op`=00, `pc_write`, `pc_source`=00. Next state is DECODE.
- DECODE: `alu_src_b`=11, `alu_op`=00 (computes the branch target). Next state by `op`:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other value → FETCH, with `illegal_op`=1 during the DECODE cycle.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next state is MEMRD if `op`==OP_LW, otherwise MEMWR.
- MEMRD: `mem_read`, `i_or_d`=1. Next state is MEMWB.
- MEMWB: `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Next state is FETCH.
- MEMWR: `mem_write`, `i_or_d`=1. Next state is FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state is ALUWB.
- ALUWB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Next state is FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`, `pc_source`=01. Next state is FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is ADDIWB.
- ADDIWB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Next state is FETCH.
- JUMP: `pc_write`, `pc_source`=10. Next state is FETCH.
- Unused codes 13–15 → IDLE on the next edge, with all outputs 0.
- `op` is sampled only in DECODE and MEMADR. The instruction register is stable in both, because `ir_write` is 0 there.
- Invariants:
  - `mem_read` and `mem_write` are never both 1.
  - `pc_write` and `pc_write_cond` are never both 1.

## Timing
- Reset:
  - `reset_n`=0 forces `state`=IDLE immediately (asynchronous).
  - Every output is 0 while `reset_n`=0 and while in IDLE.
  - First FETCH is on the first rising edge after `reset_n` deasserts.
- Reset asserted mid-instruction aborts it immediately, with no write strobe after assertion. Execution restarts at IDLE then FETCH.
- Cycles per instruction, FETCH through last state inclusive:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Outputs change only after a rising edge or on asynchronous reset assertion. They are glitch-free relative to `state`, meaning decoded from the registered state only.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset_n`=0 for 3 cycles, then release with `op`=6'h00.
  - Required: all outputs 0 during reset. `state` sequence 0,1,2,7,8,1. `reg_write`=1 and `reg_dst`=1 only in state 8.
- lw (`op`=6'h23):
  - Required: states 1,2,3,4,5,1.
  - `i_or_d`=1 and `mem_read`=1 in state 4.
  - `reg_write`=1 and `mem_to_reg`=1 in state 5.
  - Exactly 5 cycles.
- sw (`op`=6'h2B):
  - Required: states 1,2,3,6,1.
  - `mem_write`=1 for exactly one cycle, with `i_or_d`=1.
  - `reg_write` stays 0 throughout.
- beq (`op`=6'h04), then j (`op`=6'h02):
  - beq required: `pc_write_cond`=1, `alu_op`=01, `pc_source`=01 in state 9.
  - j required: `pc_write`=1, `pc_source`=10 in state 12.
  - Each instruction takes 3 cycles.
- Illegal opcode (`op`=6'h3F):
  - Required: states 1,2,1. `illegal_op`=1 for exactly the one DECODE cycle, with no write enables in that cycle.
  - Then addi (`op`=6'h08) → states 1,2,10,11,1.
- Reset asserted asynchronously mid-MEMRD, between clock edges:
  - Required: `state`=0 and all outputs 0 before the next edge.
  - Recovery: FETCH on the first edge after release.
  - Continuous check: mem_read/mem_write exclusivity and pc_write/pc_write_cond exclusivity on every cycle.
